// File: rtl/jk_ctrl_pkg.sv
// Shared definitions for the JK bank controller: op encodings, FSM state type
// and round-robin pointer values.
package jk_ctrl_pkg;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_TGL  = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

endpackage

// File: rtl/jk_cell.sv
// One JK flip-flop of the bank; async active-low reset clears Q.
module jk_cell
  import jk_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic Qn
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Q <= 1'b0;
    end else begin
      case ({J, K})
        OP_CLR:  Q <= 1'b0;
        OP_SET:  Q <= 1'b1;
        OP_TGL:  Q <= ~Q;
        default: Q <= Q;
      endcase
    end
  end

  assign Qn = ~Q;

endmodule

// File: rtl/jk_bank_ctrl.sv
// Two-requester round-robin controller driving a bank of JK cells.
// One command per two cycles: IDLE accepts, APPLY drives J/K for one edge.
module jk_bank_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter  int N_BITS = 4,
  localparam int IDX_W  = (N_BITS > 2) ? $clog2(N_BITS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [IDX_W-1:0]  a_idx,
  input  logic [1:0]        a_op,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [IDX_W-1:0]  b_idx,
  input  logic [1:0]        b_op,
  output logic [N_BITS-1:0] q,
  output logic [N_BITS-1:0] qn,
  output logic              done,
  output logic              done_id,
  output logic              err,
  output state_t            dbg_state
);

  // Handshake: a command transfers at a rising edge where valid & ready are
  // both high; ready is only offered in IDLE, to at most one requester, and
  // a requester keeps valid/idx/op steady until it sees ready.

  localparam logic [IDX_W:0] N_LIM = (IDX_W + 1)'(N_BITS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_ptr;
  logic             r_req;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_op;
  logic             r_done;
  logic             r_done_id;
  logic             r_err;

  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_hs;
  logic             w_oob;
  logic [N_BITS-1:0] w_j;
  logic [N_BITS-1:0] w_k;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_a   = 1'b0;
    w_grant_b   = 1'b0;
    case (r_state)
      IDLE: begin
        // A lone requester wins outright; a tie goes to the pointer.
        if (a_valid && (!b_valid || r_ptr == PTR_A)) begin
          w_grant_a = 1'b1;
        end else if (b_valid) begin
          w_grant_b = 1'b1;
        end
        if (w_grant_a || w_grant_b) begin
          w_state_nxt = APPLY;
        end
      end
      APPLY:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Gated by rst_n so no ready escapes while reset is held.
  assign a_ready = rst_n & w_grant_a;
  assign b_ready = rst_n & w_grant_b;
  assign w_hs    = a_ready | b_ready;
  assign w_oob   = {1'b0, r_idx} >= N_LIM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= PTR_A;
      r_req     <= 1'b0;
      r_idx     <= '0;
      r_op      <= OP_HOLD;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == APPLY);
      if (r_state == APPLY) begin
        r_done_id <= r_req;
        r_err     <= w_oob;
      end
      if (w_hs) begin
        r_req <= w_grant_b;
        r_ptr <= w_grant_a;
        r_idx <= w_grant_b ? b_idx : a_idx;
        r_op  <= w_grant_b ? b_op  : a_op;
      end
    end
  end

  for (genvar gi = 0; gi < N_BITS; gi++) begin : g_cell
    logic w_sel;
    assign w_sel   = (r_state == APPLY) && (r_idx == IDX_W'(gi));
    assign w_j[gi] = w_sel & r_op[1];
    assign w_k[gi] = w_sel & r_op[0];

    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .J     (w_j[gi]),
      .K     (w_k[gi]),
      .Q     (q[gi]),
      .Qn    (qn[gi])
    );
  end

  assign done      = r_done;
  assign done_id   = r_done_id;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: doc/jk_bank_ctrl.md
JK_BANK_CTRL -- requirements
Module: jk_bank_ctrl

Interface
REQ-001 The block SHALL have parameter N_BITS, default 4: number of JK cells in the bank, legal range 2..16.
REQ-002 The block SHALL have localparam IDX_W = clog2(N_BITS), minimum 1: cell-index width.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have ports a_valid / b_valid, input, 1 each: the requester A / B command is valid.
REQ-006 The block SHALL have ports a_ready / b_ready, output, 1 each: the requester A / B command is accepted this cycle.
REQ-007 The block SHALL have ports a_idx / b_idx, input, IDX_W each: target cell.
REQ-008 The block SHALL have ports a_op / b_op, input, 2 each: 00 hold (J=0,K=0), 01 clear (J=0,K=1), 10 set (J=1,K=0), 11 toggle (J=1,K=1).
REQ-009 The block SHALL have port q, output, N_BITS: the cell states.
REQ-010 The block SHALL have port qn, output, N_BITS: always ~q.
REQ-011 The block SHALL have port done, output, 1: one-cycle pulse that a command has completed.
REQ-012 The block SHALL have port done_id, output, 1: requester of the completed command (0=A, 1=B); valid only when done=1.
REQ-013 The block SHALL have port err, output, 1: the completed command had idx >= N_BITS; valid only when done=1.

Function
REQ-014 The controller SHALL implement the FSM states IDLE and APPLY only.
REQ-015 In IDLE, the controller SHALL assert at most one ready, and SHALL assert it combinationally from the valids and the round-robin pointer.
REQ-016 In APPLY, both readies SHALL be 0.
REQ-017 A handshake SHALL be valid&ready at a rising edge; on a handshake the block SHALL register requester, idx and op and go IDLE->APPLY.
REQ-018 Arbitration SHALL be round-robin: when both valids are high, grant goes to the requester indicated by the pointer; after each grant, the pointer points to the other requester.
REQ-019 When only one valid is high, that requester SHALL be granted regardless of the pointer, and the pointer still updates per REQ-018.
REQ-020 During APPLY, the controller SHALL drive J/K of the target cell from the registered op and J=0,K=0 to all other cells.
REQ-021 The controller SHALL return APPLY->IDLE unconditionally at the next edge.
REQ-022 Each cell SHALL follow JK semantics at the APPLY-ending edge: 00 Q holds, 01 Q=0, 10 Q=1, 11 Q=~Q.
REQ-023 Latency: for a handshake at edge N, the new q SHALL be visible after edge N+1, with done=1 during the cycle after edge N+1.
REQ-024 Peak throughput SHALL be one command per 2 cycles; a requester holding valid SHALL see ready again in the cycle in which done=1.
REQ-025 A command with idx >= N_BITS SHALL be accepted and SHALL leave all cells unchanged, and done SHALL pulse with err=1; otherwise err=0.
REQ-026 Cells not addressed by a command SHALL never change state.
REQ-027 A requester SHALL hold valid, idx and op stable until ready; the block need not tolerate withdrawal before acceptance.
REQ-028 done, done_id and err SHALL be registered outputs.

Reset
REQ-029 Assertion of rst_n=0 SHALL take effect immediately, independent of clk.
REQ-030 During reset: FSM=IDLE, q=0, qn=all ones, done=0, done_id=0, err=0, pointer=A, a_ready=b_ready=0.
REQ-031 Reset asserted during APPLY SHALL abort the command: no cell updates, no done pulse.
REQ-032 After rst_n rises, arbitration SHALL resume at the first rising edge, with A having priority.

Structure
REQ-033 Op encodings (OP_HOLD, OP_CLR, OP_SET, OP_TGL) and the FSM state type SHALL live in shared package jk_ctrl_pkg.
REQ-034 Each bank bit SHALL be one instance of sub-module jk_cell, with ports clk, rst_n, J, K, Q, Qn, async-low reset to Q=0, and no other logic.
REQ-035 The arbiter, FSM and J/K decode SHALL reside in jk_bank_ctrl; there SHALL be no additional sub-modules.

Verification
REQ-036 The bench SHALL cover: after reset, A valid idx=2 op=10 -> a_ready=1; q=0100 one edge after acceptance; done=1, done_id=0, err=0.
REQ-037 The bench SHALL cover: A and B both valid continuously, ops toggle on idx 0 -> grants alternate A,B,A,B starting with A; q[0] toggles every 2 cycles.
REQ-038 The bench SHALL cover: q=1111, B op=11 idx=3, then op=01 idx=1 -> q=0111, then q=0101; other bits unchanged.
REQ-039 The bench SHALL cover: idx out of range (N_BITS=3, idx=3, op=10) -> q unchanged, done=1, err=1.
REQ-040 The bench SHALL cover: rst_n pulled low mid-APPLY (op=10 idx=1) -> q=0000 immediately, no done, A granted first after release.
REQ-041 The bench SHALL cover: op=00 on idx 0 with q=0001 -> q unchanged, done=1, err=0.
